// File: rtl/sb_injector_pkg.sv
// sb_injector_pkg: shared MinBD router types and constants (flit width, slot indices, slot record)
package sb_injector_pkg;

    localparam int FLIT_W = 11;

    localparam int SLOT_E = 0;
    localparam int SLOT_W = 1;
    localparam int SLOT_N = 2;
    localparam int SLOT_S = 3;
    localparam int NSLOT  = 4;

    typedef struct packed {
        logic [FLIT_W-1:0] ad;
        logic              v;
    } slot_t;

endpackage

// File: rtl/sb_inj_sel.sv
// sb_inj_sel: first-empty priority picker, slot 0 (east) highest
//   v     in  4  slot valids, bit k = slot k
//   req   in  1  injection request
//   grant out 4  one-hot slot chosen for the injection flit, zero if none
//   ack   out 1  injection accepted
module sb_inj_sel
    import sb_injector_pkg::*;
(
    input  logic [NSLOT-1:0] v,
    input  logic             req,
    output logic [NSLOT-1:0] grant,
    output logic             ack
);
    // adding one to the valid vector carries through the low run of ones,
    // so masking with ~v isolates the lowest zero bit; all-full gives zero
    assign grant = req ? (~v & (v + NSLOT'(1))) : '0;
    assign ack   = req & ~&v;
endmodule

// File: rtl/sb_injector.sv
// sb_injector: MinBD injection stage, drops the pending flit into the first empty link slot
//   clk, rst                        clock, synchronous active-high reset
//   eastad/westad/northad/southad   slot 0..3 input flits, with valids eastv..southv
//   crinject, crinjectv             flit offered for injection and its request
//   crinject_ack                    combinational, high when crinject is taken this cycle
//   ead/wad/nad/sad, ev/wv/nv/sv    registered slot 0..3 flits and valids
module sb_injector #(
    parameter int FLIT_W = sb_injector_pkg::FLIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] eastad,
    input  logic              eastv,
    input  logic [FLIT_W-1:0] westad,
    input  logic              westv,
    input  logic [FLIT_W-1:0] northad,
    input  logic              northv,
    input  logic [FLIT_W-1:0] southad,
    input  logic              southv,
    input  logic [FLIT_W-1:0] crinject,
    input  logic              crinjectv,
    output logic              crinject_ack,
    output logic [FLIT_W-1:0] ead,
    output logic [FLIT_W-1:0] wad,
    output logic [FLIT_W-1:0] nad,
    output logic [FLIT_W-1:0] sad,
    output logic              ev,
    output logic              wv,
    output logic              nv,
    output logic              sv
);
    localparam int NSLOT = sb_injector_pkg::NSLOT;

    logic [NSLOT-1:0]  vin;
    logic [FLIT_W-1:0] din   [NSLOT];
    logic [NSLOT-1:0]  grant;
    logic [NSLOT-1:0]  nxt_v;
    logic [FLIT_W-1:0] nxt_d [NSLOT];
    logic [NSLOT-1:0]  q_v;
    logic [FLIT_W-1:0] q_d   [NSLOT];

    assign vin = {southv, northv, westv, eastv};
    assign din[sb_injector_pkg::SLOT_E] = eastad;
    assign din[sb_injector_pkg::SLOT_W] = westad;
    assign din[sb_injector_pkg::SLOT_N] = northad;
    assign din[sb_injector_pkg::SLOT_S] = southad;

    // gating the request with rst keeps an injection from being acked and then lost in reset
    sb_inj_sel u_sel (
        .v     (vin),
        .req   (crinjectv & ~rst),
        .grant (grant),
        .ack   (crinject_ack)
    );

    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            nxt_v[k] = vin[k] | grant[k];
            nxt_d[k] = grant[k] ? crinject : vin[k] ? din[k] : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NSLOT; k++) begin
            q_v[k] <= rst ? 1'b0 : nxt_v[k];
            q_d[k] <= rst ? '0 : nxt_d[k];
        end
    end

    assign ead = q_d[sb_injector_pkg::SLOT_E];
    assign wad = q_d[sb_injector_pkg::SLOT_W];
    assign nad = q_d[sb_injector_pkg::SLOT_N];
    assign sad = q_d[sb_injector_pkg::SLOT_S];
    assign ev  = q_v[sb_injector_pkg::SLOT_E];
    assign wv  = q_v[sb_injector_pkg::SLOT_W];
    assign nv  = q_v[sb_injector_pkg::SLOT_N];
    assign sv  = q_v[sb_injector_pkg::SLOT_S];
endmodule

// File: tb/tb_sb_injector.sv
// tb_sb_injector: directed and randomized check of sb_injector against a slot-list reference model
module tb_sb_injector;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] eastad, westad, northad, southad, crinject;
    logic         eastv, westv, northv, southv, crinjectv;
    logic         crinject_ack;
    logic [W-1:0] ead, wad, nad, sad;
    logic         ev, wv, nv, sv;

    int checks = 0;
    int passes = 0;

    sb_injector #(.FLIT_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .eastad       (eastad),
        .eastv        (eastv),
        .westad       (westad),
        .westv        (westv),
        .northad      (northad),
        .northv       (northv),
        .southad      (southad),
        .southv       (southv),
        .crinject     (crinject),
        .crinjectv    (crinjectv),
        .crinject_ack (crinject_ack),
        .ead          (ead),
        .wad          (wad),
        .nad          (nad),
        .sad          (sad),
        .ev           (ev),
        .wv           (wv),
        .nv           (nv),
        .sv           (sv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%b exp=%b", tag, got, exp);
    endtask

    // model: an empty slot is one with valid low; the injection lands in the first
    // empty slot scanning east, west, north, south; reset clears everything
    task automatic step(input string name, input logic r, input logic [3:0] v,
                        input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] a2, input logic [W-1:0] a3,
                        input logic [W-1:0] inj, input logic injv);
        logic [W-1:0] ain [4];
        logic [W-1:0] ed  [4];
        logic [3:0]   evv;
        logic         eack;
        ain = '{a0, a1, a2, a3};
        @(negedge clk);
        rst = r;
        {southv, northv, westv, eastv} = v;
        eastad = a0; westad = a1; northad = a2; southad = a3;
        crinject = inj; crinjectv = injv;
        eack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            evv[k] = !r && v[k];
            ed[k]  = evv[k] ? ain[k] : '0;
        end
        if (!r && injv)
            for (int k = 0; k < 4; k++)
                if (!eack && !v[k]) begin
                    evv[k] = 1'b1;
                    ed[k]  = inj;
                    eack   = 1'b1;
                end
        #1 check({name, ".ack"}, W'(crinject_ack), W'(eack));
        @(posedge clk);
        #1;
        check({name, ".ev"},  W'(ev), W'(evv[0]));
        check({name, ".wv"},  W'(wv), W'(evv[1]));
        check({name, ".nv"},  W'(nv), W'(evv[2]));
        check({name, ".sv"},  W'(sv), W'(evv[3]));
        check({name, ".ead"}, ead, ed[0]);
        check({name, ".wad"}, wad, ed[1]);
        check({name, ".nad"}, nad, ed[2]);
        check({name, ".sad"}, sad, ed[3]);
    endtask

    initial begin
        rst = 1'b1;
        {eastv, westv, northv, southv, crinjectv} = '0;
        {eastad, westad, northad, southad, crinject} = '0;

        step("reset", 1, 4'b1111, 11'h7ff, 11'h555, 11'h2aa, 11'h123, 11'h3c3, 1);
        step("single", 0, 4'b0001, 11'b00000101100, 11'h7ff, 11'h7ff, 11'h7ff, 11'b00000100000, 1);
        step("east_empty", 0, 4'b1010, 11'h3ff, 11'b00000010001, 11'h1ff, 11'b00000000001, 11'b00000101100, 1);
        step("all_full", 0, 4'b1111, 11'b00000001100, 11'b00000010101, 11'b00000111100, 11'b00000000011, 11'b00000001100, 1);
        step("north_empty", 0, 4'b1011, 11'b10000100001, 11'h0f0, 11'h7ff, 11'h00f, 11'b00000111111, 1);
        step("south_empty", 0, 4'b0111, 11'h001, 11'h002, 11'h004, 11'h7ff, 11'h444, 1);
        step("all_empty", 0, 4'b0000, 11'h7ff, 11'h7ff, 11'h7ff, 11'h7ff, 11'h0aa, 1);
        step("no_req", 0, 4'b0101, 11'h135, 11'h7ff, 11'h246, 11'h7ff, 11'h3a5, 0);
        step("pre_rst", 0, 4'b1101, 11'h111, 11'h222, 11'h333, 11'h444, 11'h555, 1);
        step("mid_rst", 1, 4'b1111, 11'h111, 11'h222, 11'h333, 11'h444, 11'h555, 1);
        step("post_rst", 0, 4'b1101, 11'h111, 11'h222, 11'h333, 11'h444, 11'h555, 1);
        step("b2b", 0, 4'b0100, 11'h0c0, 11'h0d0, 11'h0e0, 11'h0f0, 11'h600, 1);

        for (int i = 0; i < 400; i++)
            step("rand", $urandom_range(0, 24) == 0, 4'($urandom),
                 W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                 W'($urandom), $urandom_range(0, 3) != 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
